// File: rtl/rr_grant_decoder8.sv
// Round-robin arbiter for 8 requesters. The registered one-hot grant is decoded from a
// 3-bit winner index, and a hold limit forces release so no requester starves the others.
module rr_grant_decoder8 #(
   parameter int HOLD_W   = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic       force_rel
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t            state;
   logic [2:0]        ptr;
   logic [HOLD_W-1:0] hold_cnt;
   logic [2:0]        pick;
   logic              limit_hit;

   function automatic logic [7:0] dec3to8(input logic [2:0] idx);
      dec3to8 = 8'b1 << idx;
   endfunction

   // Scan from lowest to highest priority so the first requester at or after ptr wins.
   always_comb begin
      pick = ptr;
      for (int k = 7; k >= 0; k--) begin
         if (req[ptr + 3'(k)]) pick = ptr + 3'(k);
      end
   end

   assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 3'd0;
         hold_cnt  <= '0;
         gnt       <= 8'd0;
         gnt_idx   <= 3'd0;
         gnt_valid <= 1'b0;
         force_rel <= 1'b0;
      end else begin
         force_rel <= 1'b0;
         case (state)
            IDLE: begin
               if (req != 8'd0) begin
                  gnt_idx   <= pick;
                  gnt       <= dec3to8(pick);
                  gnt_valid <= 1'b1;
                  hold_cnt  <= '0;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               // A voluntary release takes precedence, so force_rel only fires while req is still held.
               if (!req[gnt_idx] || limit_hit) begin
                  gnt       <= 8'd0;
                  gnt_valid <= 1'b0;
                  ptr       <= gnt_idx + 3'd1;
                  force_rel <= req[gnt_idx];
                  state     <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_grant_decoder8.sv
// Randomized and directed bench for rr_grant_decoder8 against an integer-level
// round-robin model (owner, pointer, cycles held).
module tb_rr_grant_decoder8;
   localparam int MH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'd0;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       force_rel;

   int n_checks = 0;
   int n_errors = 0;

   int m_owner;   // -1 when no grant is active
   int m_last;
   int m_ptr;
   int m_held;    // cycles the current grant has been visible
   bit m_force;

   rr_grant_decoder8 #(.HOLD_W(8), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt),
      .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .force_rel(force_rel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0; m_force = 0;
   endtask

   task automatic model_release(input bit forced);
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
      m_force = forced;
   endtask

   task automatic model_edge();
      bit found;
      m_force = 0;
      if (m_owner < 0) begin
         found = 0;
         for (int k = 0; k < 8; k++) begin
            int i;
            i = (m_ptr + k) % 8;
            if (!found && req[i]) begin
               found = 1; m_owner = i; m_last = i; m_held = 1;
            end
         end
      end else if (!req[m_owner]) begin
         model_release(0);
      end else if (MH != 0 && m_held == MH) begin
         model_release(1);
      end else begin
         m_held++;
      end
   endtask

   task automatic check_outs();
      check("gnt",       32'(gnt),       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("gnt_idx",   32'(gnt_idx),   32'(m_last));
      check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
      check("force_rel", 32'(force_rel), 32'(m_force));
   endtask

   task automatic step(input logic [7:0] r);
      req = r;
      @(posedge clk);
      model_edge();
      #1;
      check_outs();
   endtask

   task automatic do_reset();
      req = 8'd0;
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_gnt",   32'(gnt),       32'd0);
      check("rst_valid", 32'(gnt_valid), 32'd0);
      check("rst_idx",   32'(gnt_idx),   32'd0);
      check("rst_force", 32'(force_rel), 32'd0);
      @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] r;

      // Reset then single request; drop moves ptr to 5.
      do_reset();
      step(8'h10);
      check("single_gnt", 32'(gnt), 32'h10);
      check("single_idx", 32'(gnt_idx), 32'd4);
      step(8'h00);
      check("single_drop", 32'(gnt), 32'h00);
      step(8'h21);
      check("ptr5_idx", 32'(gnt_idx), 32'd5);

      // Fairness: all requesting, each grant dropped after two cycles.
      do_reset();
      for (int g = 0; g < 9; g++) begin
         step(8'hFF);
         check("rr_idx", 32'(gnt_idx), 32'(g % 8));
         step(8'hFF);
         step(8'hFF & ~(8'd1 << (g % 8)));
         check("rr_gap", 32'(gnt), 32'd0);
      end

      // Hold limit with two permanent requesters.
      do_reset();
      for (int c = 1; c <= 20; c++) begin
         step(8'h03);
         if (c == 5 || c == 15) check("hold_force", 32'(force_rel), 32'd1);
         if (c >= 6 && c <= 9) check("hold_second", 32'(gnt), 32'h02);
         if (c >= 11 && c <= 14) check("hold_back", 32'(gnt), 32'h01);
      end

      // Release on the same edge the limit is reached.
      do_reset();
      for (int c = 0; c < 4; c++) step(8'h01);
      step(8'h00);
      check("simul_force", 32'(force_rel), 32'd0);
      check("simul_gnt", 32'(gnt), 32'd0);
      step(8'h03);
      check("simul_ptr1", 32'(gnt_idx), 32'd1);

      // Pointer wrap from 7 to 0.
      do_reset();
      step(8'h40);
      step(8'h00);
      step(8'h81);
      check("wrap_7", 32'(gnt_idx), 32'd7);
      step(8'h00);
      step(8'h81);
      check("wrap_0", 32'(gnt_idx), 32'd0);

      // Async reset in the middle of a grant.
      do_reset();
      step(8'h20);
      check("async_pre", 32'(gnt), 32'h20);
      #2;
      rst = 1'b1;
      #1;
      check("async_gnt",   32'(gnt),       32'd0);
      check("async_valid", 32'(gnt_valid), 32'd0);
      model_reset();
      #2;
      rst = 1'b0;
      step(8'h30);
      check("async_idx4", 32'(gnt_idx), 32'd4);

      // Random traffic with persistent, occasionally toggling requests.
      do_reset();
      r = 8'd0;
      for (int c = 0; c < 3000; c++) begin
         r = r ^ 8'($urandom & $urandom & $urandom);
         step(r);
         check("inv_onehot", 32'($onehot0(gnt)), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/rr_grant_decoder8.md
Name: rr_grant_decoder8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Internally holds a 3-bit winner index and decodes it to a registered one-hot grant vector.
- The index-to-one-hot decode is the same 3-to-8 decode function used elsewhere in the design, so the grant can drive per-requester enables directly.
- Sits between requester blocks and the shared resource. Adds a hold limit so no requester starves the others.

Parameters:
- HOLD_W, 8, width of the hold counter.
- MAX_HOLD, 16, maximum cycles a grant may be held. 0 means unlimited. Must satisfy MAX_HOLD < 2^HOLD_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- req  in  8  request lines. Requester i holds req[i] high for the whole time it uses the resource.
- gnt  out  8  registered one-hot grant. All zero when no grant is active.
- gnt_idx  out  3  binary index of the current or last winner.
- gnt_valid  out  1  high while a grant is active. Equals the OR of gnt.
- force_rel  out  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (async, rst=1), applied immediately including mid-grant:
  - gnt=0, gnt_idx=0, gnt_valid=0, force_rel=0.
  - ptr=0, hold_cnt=0, state=IDLE.
- Internal state:
  - ptr (3 bits): highest-priority index for the next arbitration.
  - hold_cnt (HOLD_W bits).
  - FSM states: IDLE, GRANT.
- IDLE:
  - If req==0: stay in IDLE, outputs unchanged.
  - Otherwise pick the first i with req[i]=1, searching ptr, ptr+1, … ptr+7 modulo 8.
  - At the clock edge: gnt_idx=i, gnt=one-hot(i), gnt_valid=1, hold_cnt=0, state=GRANT.
  - Latency: a req sampled at edge N produces gnt visible after edge N.
- GRANT (hold_cnt increments every cycle):
  - Voluntary release: if req[gnt_idx]=0 at an edge, then at that edge gnt=0, gnt_valid=0, ptr=gnt_idx+1 (wraps 7 to 0), state=IDLE.
  - Forced release: if MAX_HOLD≠0, req[gnt_idx]=1 and hold_cnt==MAX_HOLD-1, then do the same as voluntary release and also set force_rel=1 for exactly one cycle. The grant was therefore held exactly MAX_HOLD cycles.
  - If both release conditions are true on the same edge, voluntary release wins and force_rel stays 0.
  - Requests from other requesters are ignored while in GRANT. No preemption.
- Arbitration gap: at least one cycle with gnt=0 between consecutive grants, including a re-grant to the same requester. Arbitration happens only in IDLE.
- gnt_idx keeps the last winner while idle. Consumers must qualify it with gnt_valid.
- force_rel is 0 on every cycle except the cycle immediately after a forced release.
- Invariant: gnt is always 0 or exactly one-hot, and gnt == (gnt_valid ? one-hot(gnt_idx) : 0).
- A requester that was force-released and keeps req high is re-arbitrated normally. Because ptr has moved past it, it has lowest priority in the next round.

Test Plan:
- Reset then single request: rst pulse, req=8'h10 → after the first edge gnt=8'h10, gnt_idx=4, gnt_valid=1. Drop req → next edge gnt=0 and ptr=5.
- Round-robin fairness: req=8'hFF held, each grant dropped after 2 cycles → grant order 0,1,…,7,0 with a one-cycle gnt=0 gap between each.
- Hold limit: MAX_HOLD=4, req=8'h03 held permanently → gnt=8'h01 for exactly 4 cycles, force_rel pulse, one idle cycle, then gnt=8'h02 for 4 cycles, then back to 8'h01.
- Simultaneous release and limit: MAX_HOLD=4, req[0] drops on the same edge where hold_cnt=3 → grant ends, force_rel stays 0, ptr=1.
- Pointer wrap: ptr=7 (after releasing a grant to index 6), req=8'h81 → index 7 granted first, then index 0.
- Async reset mid-grant: rst asserted between edges while gnt=8'h20 → gnt=0 and gnt_valid=0 immediately with no clock edge. After release, req=8'h30 → index 4 granted (ptr back to 0).
